osc_seq_monitor: RTL and testbench

Downstream checker for the 2-bit `Oscillator` FSM. Each cycle it samples the oscillator's `state` output and its mode input `A`, and checks that every transition follows the legal rule:
- `A=0`: bit0 toggles, bit1 holds.
- `A=1`: bit1 toggles, bit0 holds.

It reports lock, per-cycle errors, a saturating error count and a sticky fault. System control logic uses these outputs to qualify the oscillator before acting on its state.

---
 rtl/osc_seq_monitor.sv | 119 +++++++++++
 tb/tb_osc_seq_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/osc_seq_monitor.sv
// Checks every state transition of the 2-bit oscillator against the previous state and mode bit; tracks lock/fault.
// Latency: err_pulse, err_count, locked and fault update one edge after the offending state is sampled.
// Backpressure: none; a passive observer that samples every cycle and never stalls its source.
module osc_seq_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 A,
  input  logic [1:0]           state,
  input  logic                 clr,
  output logic                 locked,
  output logic                 fault,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           mon_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10,
    FAULT  = 2'b11
  } mon_st_t;

  localparam logic [7:0]           LOCK_TGT = 8'(LOCK_COUNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  mon_st_t cur_st, nxt_st;

  logic [1:0] prev_state;
  logic       prev_a;
  logic [7:0] run_cnt;
  logic [1:0] exp_state;
  logic       mismatch;
  logic       check_en;
  logic       err_det;
  logic       run_hit;

  // The mode bit that produced the current state is last cycle's A, so mode switches are never flagged.
  assign exp_state = prev_a ? {~prev_state[1], prev_state[0]}
                            : {prev_state[1], ~prev_state[0]};
  assign mismatch  = (state != exp_state);
  assign check_en  = (cur_st == TRACK) || (cur_st == LOCKED);
  assign err_det   = check_en && mismatch && !clr;
  assign run_hit   = ((run_cnt + 8'd1) == LOCK_TGT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st <= IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  always_comb begin
    nxt_st = cur_st;
    if (clr) begin
      nxt_st = IDLE;
    end else begin
      case (cur_st)
        IDLE:    nxt_st = TRACK;
        TRACK:   if (!mismatch && run_hit) nxt_st = LOCKED;
        LOCKED:  if (mismatch) nxt_st = FAULT;
        FAULT:   nxt_st = FAULT;
        default: nxt_st = IDLE;
      endcase
    end
  end

  always_comb begin
    locked    = (cur_st == LOCKED);
    fault     = (cur_st == FAULT);
    mon_state = cur_st;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state <= 2'b00;
      prev_a     <= 1'b0;
    end else if (!clr) begin
      prev_state <= state;
      prev_a     <= A;
    end
  end

  // Run length only advances while tracking; it is frozen once locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= 8'd0;
    end else if (clr) begin
      run_cnt <= 8'd0;
    end else begin
      case (cur_st)
        IDLE:    run_cnt <= 8'd0;
        TRACK:   run_cnt <= mismatch ? 8'd0 : run_cnt + 8'd1;
        LOCKED:  if (mismatch) run_cnt <= 8'd0;
        default: run_cnt <= run_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else if (clr) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= err_det;
      if (err_det && (err_count != ERR_MAX)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_osc_seq_monitor.sv
// Directed scenarios plus randomized oscillator traffic, compared every cycle against a behavioural model.
module tb_osc_seq_monitor;
  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       A;
  logic       clr;
  logic [1:0] state;

  logic       locked, fault, err_pulse;
  logic [7:0] err_count;
  logic [1:0] mon_state;
  logic       s_locked, s_fault, s_err_pulse;
  logic [1:0] s_err_count;
  logic [1:0] s_mon_state;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0=idle 1=track 2=locked 3=fault, unbounded error tally.
  int         m_phase;
  int         m_run;
  int         m_errs;
  bit         m_pulse;
  logic [1:0] m_prev;
  logic       m_prev_a;

  logic [1:0] osc;
  logic [1:0] s_stim;
  logic       a_stim;
  logic       c_stim;

  osc_seq_monitor #(.LOCK_COUNT(LOCK), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .A(A), .state(state), .clr(clr),
    .locked(locked), .fault(fault), .err_pulse(err_pulse),
    .err_count(err_count), .mon_state(mon_state)
  );

  osc_seq_monitor #(.LOCK_COUNT(LOCK), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .A(A), .state(state), .clr(clr),
    .locked(s_locked), .fault(s_fault), .err_pulse(s_err_pulse),
    .err_count(s_err_count), .mon_state(s_mon_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] osc_next(input logic [1:0] s, input logic a);
    return a ? (s ^ 2'b10) : (s ^ 2'b01);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_run    = 0;
    m_errs   = 0;
    m_pulse  = 0;
    m_prev   = 2'b00;
    m_prev_a = 1'b0;
  endtask

  task automatic model_edge();
    bit legal;
    if (clr) begin
      m_phase = 0;
      m_run   = 0;
      m_errs  = 0;
      m_pulse = 0;
      return;
    end
    legal   = (state == osc_next(m_prev, m_prev_a));
    m_pulse = 0;
    case (m_phase)
      0: begin m_phase = 1; m_run = 0; end
      1: begin
        if (!legal) begin m_pulse = 1; m_errs++; m_run = 0; end
        else begin
          m_run++;
          if (m_run == LOCK) m_phase = 2;
        end
      end
      2: if (!legal) begin m_pulse = 1; m_errs++; m_phase = 3; end
      default: ;
    endcase
    m_prev   = state;
    m_prev_a = A;
  endtask

  task automatic check_outputs();
    chk("locked",    locked,      m_phase == 2);
    chk("fault",     fault,       m_phase == 3);
    chk("pulse",     err_pulse,   m_pulse);
    chk("count",     err_count,   sat(m_errs, 255));
    chk("mon",       mon_state,   m_phase);
    chk("sat_count", s_err_count, sat(m_errs, 3));
    chk("sat_pulse", s_err_pulse, m_pulse);
    chk("sat_mon",   s_mon_state, m_phase);
  endtask

  task automatic step(input logic a, input logic [1:0] s, input logic c);
    A     = a;
    state = s;
    clr   = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Raise rst between edges and look at the outputs before any clock arrives.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_locked", locked,    0);
    chk("arst_count",  err_count, 0);
    chk("arst_mon",    mon_state, 0);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lock_from_clr();
    step(0, 2'b00, 1);
    step(0, 2'b01, 0);
    step(0, 2'b00, 0);
    step(0, 2'b01, 0);
    step(0, 2'b00, 0);
    step(0, 2'b01, 0);
    chk("relock", locked, 1);
  endtask

  initial begin
    rst   = 1'b1;
    A     = 1'b0;
    clr   = 1'b0;
    state = 2'b00;
    model_reset();
    @(negedge clk);
    check_outputs();
    chk("rst_mon", mon_state, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean A=0 run: lock on the fifth edge.
    step(0, 2'b00, 0);
    step(0, 2'b01, 0);
    step(0, 2'b00, 0);
    step(0, 2'b01, 0);
    chk("pre_lock", locked, 0);
    step(0, 2'b00, 0);
    chk("lock_edge5", locked, 1);
    chk("lock_mon", mon_state, 2);
    chk("lock_count", err_count, 0);

    // Mode switch while locked.
    step(1, 2'b01, 0);
    step(0, 2'b11, 0);
    chk("mode_locked", locked, 1);
    chk("mode_pulse", err_pulse, 0);

    // Error while locked, then garbage, then clr.
    step(1, 2'b10, 0);
    step(0, 2'b00, 0);
    step(0, 2'b01, 0);
    step(0, 2'b10, 0);
    chk("lk_fault", fault, 1);
    chk("lk_locked", locked, 0);
    chk("lk_count", err_count, 1);
    chk("lk_pulse", err_pulse, 1);
    step(0, 2'b11, 0);
    step(1, 2'b01, 0);
    chk("fault_hold_count", err_count, 1);
    chk("fault_hold_pulse", err_pulse, 0);
    step(0, 2'b00, 1);
    chk("clr_fault", fault, 0);
    chk("clr_count", err_count, 0);
    chk("clr_mon", mon_state, 0);

    // Error while tracking: one pulse, stays in TRACK, four more legal steps to lock.
    step(0, 2'b00, 0);
    step(0, 2'b01, 0);
    step(0, 2'b11, 0);
    chk("trk_pulse", err_pulse, 1);
    chk("trk_count", err_count, 1);
    chk("trk_mon", mon_state, 1);
    step(0, 2'b10, 0);
    chk("trk_pulse_one", err_pulse, 0);
    step(0, 2'b11, 0);
    step(0, 2'b10, 0);
    chk("trk_not_yet", locked, 0);
    step(0, 2'b11, 0);
    chk("trk_relock", locked, 1);

    // Saturation with a stuck oscillator.
    step(0, 2'b00, 1);
    step(0, 2'b00, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b00, 0);
      chk("stuck_pulse", s_err_pulse, 1);
    end
    chk("sat_at_max", s_err_count, 3);
    chk("wide_count", err_count, 5);

    // Async reset while locked.
    lock_from_clr();
    do_reset();

    // Randomized traffic with sparse glitches, clears and resets.
    osc    = 2'b00;
    a_stim = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) a_stim = ~a_stim;
        c_stim = ($urandom_range(0, 149) == 0);
        s_stim = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(0, 3)) : osc;
        step(a_stim, s_stim, c_stim);
        osc = osc_next(s_stim, a_stim);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
